// File: rtl/rf_write_arbiter.sv
// rf_write_arbiter: shares the register file's single write port between
// NUM_REQ writeback sources. After reset it zero-fills r1..r31 through the
// port, then arbitrates valid/ready requests with a one-cycle write latency.
// Optional feature macro: RFWA_ROUND_ROBIN_EN (round-robin grant; default is
// fixed priority, lowest index wins).
module rf_write_arbiter #(
  parameter int unsigned NUM_REQ    = 3,
  parameter int unsigned DATA_W     = 32,
  parameter int unsigned ADDR_W     = 5,
  parameter int unsigned INIT_SWEEP = 1
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic [NUM_REQ-1:0]         req_valid,
  input  logic [NUM_REQ*ADDR_W-1:0]  req_dest,
  input  logic [NUM_REQ*DATA_W-1:0]  req_data,
  output logic [NUM_REQ-1:0]         req_ready,
  output logic                       rf_write_en,
  output logic [ADDR_W-1:0]          rf_write_dest,
  output logic [DATA_W-1:0]          rf_write_data,
  output logic [2:0]                 grant_id,
  output logic                       init_busy
);

  localparam logic [ADDR_W-1:0] SWEEP_FIRST = ADDR_W'(1);
  localparam logic [ADDR_W-1:0] SWEEP_LAST  = ADDR_W'(31);

  typedef enum logic {
    ST_INIT = 1'b0,
    ST_ARB  = 1'b1
  } state_t;

  localparam state_t RESET_STATE = (INIT_SWEEP != 0) ? ST_INIT : ST_ARB;

  state_t              state, state_nxt;
  logic [ADDR_W-1:0]   sweep_cnt, cnt_nxt;
  logic                wr_en_nxt;
  logic [ADDR_W-1:0]   wr_dest_nxt;
  logic [DATA_W-1:0]   wr_data_nxt;
  logic [2:0]          gid_nxt;
  logic [NUM_REQ-1:0]  grant_oh;

  // One-hot of the lowest set bit (all-zero when none set).
  function automatic logic [NUM_REQ-1:0] lowest_one(input logic [NUM_REQ-1:0] v);
    logic found;
    found      = 1'b0;
    lowest_one = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (v[i] && !found) begin
        lowest_one[i] = 1'b1;
        found         = 1'b1;
      end
    end
  endfunction

`ifdef RFWA_ROUND_ROBIN_EN
  localparam int unsigned PTR_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

  logic [PTR_W-1:0]   rr_ptr, rr_ptr_nxt;
  logic [NUM_REQ-1:0] upper_valid;

  // Round-robin pick: lowest valid at or above the pointer, else wrap to lowest valid.
  always_comb begin
    upper_valid = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (i >= int'(rr_ptr)) upper_valid[i] = req_valid[i];
    end
    grant_oh = (|upper_valid) ? lowest_one(upper_valid) : lowest_one(req_valid);
  end

  // Round-robin pointer register; moves only on a transfer.
  always_ff @(posedge clk) begin
    if (reset) rr_ptr <= '0;
    else       rr_ptr <= rr_ptr_nxt;
  end
`else
  // Fixed-priority pick: lowest valid index wins.
  always_comb begin
    grant_oh = lowest_one(req_valid);
  end
`endif

  // Next-state, sweep sequencing, grant and write-port next values.
  always_comb begin
    state_nxt   = state;
    cnt_nxt     = sweep_cnt;
    wr_en_nxt   = 1'b0;
    wr_dest_nxt = rf_write_dest;
    wr_data_nxt = rf_write_data;
    gid_nxt     = grant_id;
    req_ready   = '0;
    init_busy   = 1'b0;
`ifdef RFWA_ROUND_ROBIN_EN
    rr_ptr_nxt  = rr_ptr;
`endif
    case (state)
      ST_INIT: begin
        init_busy   = 1'b1;
        wr_en_nxt   = 1'b1;
        wr_dest_nxt = sweep_cnt;
        wr_data_nxt = '0;
        // Counter saturates at the last register so it never wraps to r0.
        if (sweep_cnt == SWEEP_LAST) state_nxt = ST_ARB;
        else                         cnt_nxt   = sweep_cnt + ADDR_W'(1);
      end
      ST_ARB: begin
        req_ready = grant_oh;
        for (int i = 0; i < NUM_REQ; i++) begin
          if (grant_oh[i]) begin
            // A write to r0 is consumed but never reaches the register file.
            wr_en_nxt   = (req_dest[i*ADDR_W +: ADDR_W] != '0);
            wr_dest_nxt = req_dest[i*ADDR_W +: ADDR_W];
            wr_data_nxt = req_data[i*DATA_W +: DATA_W];
            gid_nxt     = 3'(i);
`ifdef RFWA_ROUND_ROBIN_EN
            rr_ptr_nxt  = (i == NUM_REQ - 1) ? '0 : PTR_W'(i + 1);
`endif
          end
        end
      end
      default: state_nxt = RESET_STATE;
    endcase
  end

  // State, sweep counter and registered write-port outputs.
  always_ff @(posedge clk) begin
    if (reset) begin
      state         <= RESET_STATE;
      sweep_cnt     <= SWEEP_FIRST;
      rf_write_en   <= 1'b0;
      rf_write_dest <= '0;
      rf_write_data <= '0;
      grant_id      <= '0;
    end else begin
      state         <= state_nxt;
      sweep_cnt     <= cnt_nxt;
      rf_write_en   <= wr_en_nxt;
      rf_write_dest <= wr_dest_nxt;
      rf_write_data <= wr_data_nxt;
      grant_id      <= gid_nxt;
    end
  end

endmodule
